// File: rtl/serial_nibble_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a single 4-bit carry-select slice.
// WIDTH must be a multiple of 4 and at least 4. Define SERIAL_NIBBLE_ADDER_SUB_EN to enable subtraction.

module carry_select_block (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [4:0] r0;
    logic [4:0] r1;

    // Both carry hypotheses are computed in parallel; cin only steers the final mux.
    always_comb begin
        r0     = {1'b0, a_i} + {1'b0, b_i};
        r1     = {1'b0, a_i} + {1'b0, b_i} + 5'd1;
        sum_o  = cin_i ? r1[3:0] : r0[3:0];
        cout_o = cin_i ? r1[4]   : r0[4];
    end
endmodule

module serial_nibble_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int MSB   = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] b_d;
    logic             carry_d;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic             last_nib;

`ifdef SERIAL_NIBBLE_ADDER_SUB_EN
    // a - b as a + ~b + 1; cin is ignored when subtracting.
    always_comb begin
        b_d     = sub ? ~b : b;
        carry_d = sub ? 1'b1 : cin;
    end
`else
    logic unused_sub;
    assign unused_sub = sub;

    always_comb begin
        b_d     = b;
        carry_d = cin;
    end
`endif

    always_comb begin
        a_nib    = a_q[4*idx_q +: 4];
        b_nib    = b_q[4*idx_q +: 4];
        last_nib = (idx_q == IDX_W'(NIB - 1));
    end

    carry_select_block u_slice (
        .a_i    (a_nib),
        .b_i    (b_nib),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b_d;
                        carry_q    <= carry_d;
                        sum_q      <= '0;
                        idx_q      <= '0;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_q[4*idx_q +: 4] <= slice_sum;
                    carry_q             <= slice_cout;
                    if (last_nib) begin
                        // The last slice produces the result MSB, so overflow is resolved here.
                        ovf_q       <= (a_q[MSB] == b_q[MSB]) && (slice_sum[3] != a_q[MSB]);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = carry_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed self-checking bench for serial_nibble_adder at WIDTH=16.
// Expected values follow SERIAL_NIBBLE_ADDER_SUB_EN when it is defined for the build.

module tb_serial_nibble_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    serial_nibble_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Drives one operation, waits (bounded) for out_valid, returns the result and hands it off.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc, input logic ts,
                          output logic [15:0] rs, output logic rc, output logic ro, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1; sub = ~ts;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rs = sum; rc = cout; ro = overflow;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks += 5;
        if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (sum !== 16'h0000)    begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum); end
        if (cout !== 1'b0)       begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
        if (overflow !== 1'b0)   begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        rst = 1'b0;
    endtask

    task automatic test_add;
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic        vc [5];
        logic [15:0] es [5];
        logic        ec [5];
        logic        eo [5];
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        va = '{16'h1234, 16'hFFFF, 16'h000F, 16'h7FFF, 16'h8000};
        vb = '{16'h4321, 16'h0001, 16'h0000, 16'h0001, 16'h8000};
        vc = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b0};
        es = '{16'h5555, 16'h0000, 16'h0010, 16'h8000, 16'h0000};
        ec = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b1};
        eo = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b1};
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vc[i], 1'b0, rs, rc, ro, lat);
            checks += 5;
            if (lat !== 4)      begin failures++; $display("FAIL add%0d_latency got=%0d exp=4", i, lat); end
            if (rs !== es[i])   begin failures++; $display("FAIL add%0d_sum got=%h exp=%h", i, rs, es[i]); end
            if (rc !== ec[i])   begin failures++; $display("FAIL add%0d_cout got=%b exp=%b", i, rc, ec[i]); end
            if (ro !== eo[i])   begin failures++; $display("FAIL add%0d_overflow got=%b exp=%b", i, ro, eo[i]); end
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failures++; $display("FAIL add%0d_handoff in_ready=%b out_valid=%b exp 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        @(negedge clk);
        a = 16'h00AA; b = 16'h0055; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        // A second request stays asserted with different operands; it must not be taken.
        a = 16'h1111; b = 16'h1111;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", lat); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 3;
            if (sum !== 16'h00FF)   begin failures++; $display("FAIL bp_hold%0d_sum got=%h exp=00ff", i, sum); end
            if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold%0d_out_valid got=%b exp=1", i, out_valid); end
            if (in_ready !== 1'b0)  begin failures++; $display("FAIL bp_hold%0d_in_ready got=%b exp=0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks += 2;
        if (in_ready !== 1'b1)  begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
        repeat (6) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_no_accept out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 3;
        if (out_valid !== 1'b0)  begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        if (in_ready !== 1'b1)   begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        if (sum !== 16'h0000)    begin failures++; $display("FAIL midrst_sum got=%h exp=0000", sum); end
        repeat (6) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0)  begin failures++; $display("FAIL midrst_late_out_valid got=%b exp=0", out_valid); end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
        checks += 2;
        if (lat !== 4)        begin failures++; $display("FAIL midrst_next_latency got=%0d exp=4", lat); end
        if (rs !== 16'h0002)  begin failures++; $display("FAIL midrst_next_sum got=%h exp=0002", rs); end
    endtask

    task automatic test_sub;
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
`ifdef SERIAL_NIBBLE_ADDER_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, rs, rc, ro, lat);
        checks += 4;
        if (lat !== 4)        begin failures++; $display("FAIL sub0_latency got=%0d exp=4", lat); end
        if (rs !== 16'hFFFE)  begin failures++; $display("FAIL sub0_sum got=%h exp=fffe", rs); end
        if (rc !== 1'b0)      begin failures++; $display("FAIL sub0_cout got=%b exp=0", rc); end
        if (ro !== 1'b0)      begin failures++; $display("FAIL sub0_overflow got=%b exp=0", ro); end
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, rs, rc, ro, lat);
        checks += 3;
        if (rs !== 16'h7FFF)  begin failures++; $display("FAIL sub1_sum got=%h exp=7fff", rs); end
        if (rc !== 1'b1)      begin failures++; $display("FAIL sub1_cout got=%b exp=1", rc); end
        if (ro !== 1'b1)      begin failures++; $display("FAIL sub1_overflow got=%b exp=1", ro); end
`else
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, rs, rc, ro, lat);
        checks += 4;
        if (lat !== 4)        begin failures++; $display("FAIL subdis0_latency got=%0d exp=4", lat); end
        if (rs !== 16'h000C)  begin failures++; $display("FAIL subdis0_sum got=%h exp=000c", rs); end
        if (rc !== 1'b0)      begin failures++; $display("FAIL subdis0_cout got=%b exp=0", rc); end
        if (ro !== 1'b0)      begin failures++; $display("FAIL subdis0_overflow got=%b exp=0", ro); end
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, rs, rc, ro, lat);
        checks++;
        if (rs !== 16'h000D)  begin failures++; $display("FAIL subdis1_sum got=%h exp=000d", rs); end
`endif
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        test_reset();
        test_add();
        test_backpressure();
        test_reset_mid_run();
        test_sub();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
